// File: rtl/norm2_isqrt.sv
// Sequential integer square root (floor) with remainder, one root bit per clock.
// Chains after the norm2 kernel through the same r_enable / w_enable handshake.
module norm2_isqrt #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r_enable,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               w_enable,
  output logic [WIDTH/2-1:0] result,
  output logic [WIDTH/2:0]   remainder
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] LAST = CW'(RW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] op;
  logic [RW-1:0]   root;
  logic [RW+1:0]   rem;
  logic [CW-1:0]   count;

  logic [RW+1:0]   t;
  logic [RW+1:0]   trial;
  logic            take;
  logic [RW+1:0]   rem_next;
  logic [RW-1:0]   root_next;
  logic            last_iter;

  // rem never exceeds 2*root, so its top two bits are always shifted out cleanly.
  always_comb begin
    t         = {rem[RW-1:0], op[WIDTH-1:WIDTH-2]};
    trial     = {root, 2'b01};
    take      = (t >= trial);
    rem_next  = take ? (t - trial) : t;
    root_next = {root[RW-2:0], take};
    last_iter = (state == RUN) && (count == LAST);
  end

  // NOTE: default assigned first so every path writes state_next -- no latch.
  always_comb begin
    state_next = state;
    if (r_enable) begin
      state_next = RUN;
    end else if (last_iter) begin
      state_next = DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op        <= '0;
      root      <= '0;
      rem       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      w_enable  <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else if (r_enable) begin
      op       <= operand;
      root     <= '0;
      rem      <= '0;
      count    <= '0;
      busy     <= 1'b1;
      w_enable <= 1'b0;
    end else if (state == RUN) begin
      op    <= {op[WIDTH-3:0], 2'b00};
      root  <= root_next;
      rem   <= rem_next;
      count <= count + 1'b1;
      if (last_iter) begin
        result    <= root_next;
        remainder <= rem_next[RW:0];
        w_enable  <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_norm2_isqrt.sv
// Directed bench for norm2_isqrt: vector table plus restart, reset and hold sequences.
module tb_norm2_isqrt;

  localparam int WIDTH = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r_enable;
  logic [WIDTH-1:0]  operand;
  logic              busy;
  logic              w_enable;
  logic [WIDTH/2-1:0] result;
  logic [WIDTH/2:0]  remainder;

  int checks = 0;
  int errors = 0;

  norm2_isqrt #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .operand(operand),
    .busy(busy), .w_enable(w_enable), .result(result), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] op;
    logic [63:0] root;
    logic [63:0] rem;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves r_enable low at the negedge after the load edge.
  task automatic start(input logic [63:0] op);
    r_enable = 1'b1;
    operand  = op;
    @(posedge clk);
    @(negedge clk);
    r_enable = 1'b0;
    operand  = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (!w_enable && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, bn;
    start(v.op);
    wait_done(lat, bn);
    check({v.name, " latency"}, 64'(lat), 64'd32);
    check({v.name, " busy_cycles"}, 64'(bn), 64'd32);
    check({v.name, " result"}, 64'(result), v.root);
    check({v.name, " remainder"}, 64'(remainder), v.rem);
    check({v.name, " busy_low"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int lat, bn;
    logic [63:0] held;
    logic never_done;

    vecs[0] = '{"zero",     64'd0,                   64'd0,          64'd0};
    vecs[1] = '{"kernel",   64'd332833500,           64'd18243,      64'd26451};
    vecs[2] = '{"max",      64'hFFFF_FFFF_FFFF_FFFF, 64'd4294967295, 64'd8589934590};
    vecs[3] = '{"million",  64'd1000000,             64'd1000,       64'd0};
    vecs[4] = '{"three",    64'd3,                   64'd1,          64'd2};
    vecs[5] = '{"two",      64'd2,                   64'd1,          64'd1};
    vecs[6] = '{"pow62",    64'h4000_0000_0000_0000, 64'd2147483648, 64'd0};
    vecs[7] = '{"maxsq",    64'hFFFF_FFFE_0000_0001, 64'd4294967295, 64'd0};
    vecs[8] = '{"ninety9",  64'd99,                  64'd9,          64'd18};
    vecs[9] = '{"one",      64'd1,                   64'd1,          64'd0};

    rst_n = 1'b0; r_enable = 1'b0; operand = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset w_enable", 64'(w_enable), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);

    // Back-to-back: each load is issued on the cycle after w_enable rose.
    foreach (vecs[i]) run_vec(vecs[i]);

    // DONE holds with r_enable low; next start clears w_enable on its load edge.
    repeat (5) @(negedge clk);
    check("hold w_enable", 64'(w_enable), 64'd1);
    check("hold result", 64'(result), 64'd1);
    start(64'd16);
    check("reload w_enable_low", 64'(w_enable), 64'd0);
    check("reload busy", 64'(busy), 64'd1);
    check("reload result_kept", 64'(result), 64'd1);
    wait_done(lat, bn);
    check("reload result", 64'(result), 64'd4);

    // Restart mid-run: second load wins, full latency counted from it.
    start(64'd1000000);
    repeat (9) @(negedge clk);
    start(64'd81);
    wait_done(lat, bn);
    check("restart latency", 64'(lat), 64'd32);
    check("restart result", 64'(result), 64'd9);
    check("restart remainder", 64'(remainder), 64'd0);

    // Reset mid-run abandons the computation.
    start(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset w_enable", 64'(w_enable), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset remainder", 64'(remainder), 64'd0);
    never_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (w_enable || busy) never_done = 1'b0;
    end
    check("midreset quiet", 64'(never_done), 64'd1);
    run_vec('{"sixteen", 64'd16, 64'd4, 64'd0});

    // Reset has priority over r_enable.
    rst_n = 1'b0; r_enable = 1'b1; operand = 64'd49;
    @(negedge clk);
    rst_n = 1'b1; r_enable = 1'b0;
    check("rst_prio busy", 64'(busy), 64'd0);
    check("rst_prio result", 64'(result), 64'd0);

    // r_enable held high: completion is 32 edges after the last high edge.
    r_enable = 1'b1;
    operand  = 64'd1000000;
    @(negedge clk);
    operand  = 64'd99;
    @(negedge clk);
    held = 64'd144;
    start(held);
    wait_done(lat, bn);
    check("held latency", 64'(lat), 64'd32);
    check("held result", 64'(result), 64'd12);
    check("held remainder", 64'(remainder), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/norm2_isqrt.md
Name: norm2_isqrt

Overview:
- Downstream stage of the norm2 sum-of-squares kernel.
- Captures the kernel's 64-bit result when that stage raises w_enable, and computes the integer square root (floor) plus remainder.
- Uses a sequential digit-by-digit (restoring) algorithm, one result bit per clock.
- Uses the same start-strobe / done-flag handshake as the kernel, so it chains directly: kernel w_enable/result drive this block's r_enable/operand.

Parameters:
- WIDTH, 64, operand width; must be even and >= 4. Root width is WIDTH/2; remainder width is WIDTH/2+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- r_enable  input  1  start strobe; operand is sampled on any edge where it is high.
- operand  input  WIDTH  unsigned radicand, e.g. the kernel's result.
- busy  output  1  high while iterating.
- w_enable  output  1  done flag; stays high until the next start or reset.
- result  output  WIDTH/2  floor(sqrt(operand)).
- remainder  output  WIDTH/2+1  operand - result^2.

Behaviour:
- Reset:
  - rst_n sampled low forces IDLE, busy=0, w_enable=0, result=0, remainder=0, and clears the internal op/root/rem/count.
  - Reset has priority over r_enable.
  - Reset mid-operation abandons the computation; no w_enable pulse follows.
- States:
  - IDLE -> (r_enable) RUN.
  - RUN -> (count==WIDTH/2-1, after that iteration) DONE.
  - DONE -> (r_enable) RUN.
  - r_enable in RUN also returns to RUN with fresh load (restart). The old computation is discarded and w_enable stays 0.
- Load edge (r_enable=1, rst_n=1):
  - op<=operand, root<=0, rem<=0, count<=0.
  - busy<=1, w_enable<=0.
  - result/remainder keep their old values.
- Iteration edge (RUN, r_enable=0):
  - t = (rem<<2) | op[WIDTH-1:WIDTH-2]; op <= op<<2.
  - trial = (root<<2) | 1, formed in WIDTH/2+2 bits.
  - If t >= trial: rem<=t-trial, root<=(root<<1)|1. Else rem<=t, root<=root<<1.
  - count<=count+1.
  - rem is held in WIDTH/2+2 bits internally; it never exceeds 2*root.
- Final iteration edge (count==WIDTH/2-1):
  - result<=final root, remainder<=final rem (truncated to WIDTH/2+1, which is lossless).
  - w_enable<=1, busy<=0, state<=DONE.
- Latency:
  - If load is edge E0, w_enable/result are valid after edge E(WIDTH/2), i.e. E32 for the default.
  - Throughput is one operand per WIDTH/2+1 cycles when r_enable is issued on the cycle after w_enable.
- DONE/IDLE with r_enable=0: all outputs hold; w_enable stays high in DONE.
- Unsigned arithmetic throughout; no signed interpretation of operand.
- Operand changing while busy has no effect, since it is only sampled on the load edge.
- r_enable held high for several cycles: every such edge reloads. Completion occurs WIDTH/2 edges after the last high edge.

Test Plan:
- Reset, then operand=0, r_enable pulse -> w_enable=1 exactly 32 cycles after the load edge; result=0, remainder=0; busy high for those 32 cycles.
- operand=332833500 (norm2 kernel output for a[i]=i, i<1000) -> result=18243, remainder=26451.
- Boundary values:
  - operand=2^64-1 -> result=4294967295, remainder=8589934590.
  - operand=1000000 -> result=1000, remainder=0.
  - operand=3 -> result=1, remainder=2.
- Restart: load 1000000, then at cycle 10 pulse r_enable with operand=81 -> no w_enable before 32 cycles after second load; then result=9, remainder=0.
- Reset mid-operation: load 2^64-1, drop rst_n at cycle 15 for 1 cycle -> all outputs 0, w_enable never rises. A following load of 16 -> result=4, remainder=0.
- Back-to-back chaining: norm2 kernel drives r_enable/operand; check w_enable stays high in DONE with r_enable low, and a second start clears w_enable on the load edge.
